// File: rtl/multicycle_control.sv
// Multicycle MIPS control: sequences FETCH/DECODE/EXEC/MEMRD/MEMWR/WB, waits on a memory
// ready handshake with an optional watchdog, and traps on illegal opcodes or memory timeouts.
module multicycle_control #(
    parameter int unsigned HANDSHAKE = 1,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_rdy,
    output logic       ir_we,
    output logic       pc_we,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       regwr,
    output logic [1:0] pcsrc,
    output logic       iord,
    output logic       regdst,
    output logic       alusrc,
    output logic       memtoreg,
    output logic       extop,
    output logic       rtype,
    output logic [2:0] aluop,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [2:0] state
);

    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [5:0] OpR     = 6'b000000;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpAddiu = 6'b001001;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMemRd  = 3'd3,
        StMemWr  = 3'd4,
        StWb     = 3'd5,
        StTrap   = 3'd6
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [1:0]        trap_cause_q, trap_cause_d;

    logic ir_we_c, pc_we_c, mem_rd_c, mem_wr_c, regwr_c;
    logic legal_op, mem_state, done, timeout;

    // Static datapath selects, valid in every state.
    always_comb begin
        regdst   = 1'b0;
        alusrc   = 1'b0;
        memtoreg = 1'b0;
        extop    = 1'b0;
        rtype    = 1'b0;
        aluop    = 3'b000;
        legal_op = 1'b1;
        case (op)
            OpR: begin
                regdst = 1'b1;
                rtype  = 1'b1;
                aluop  = 3'b001;
            end
            OpOri: begin
                alusrc = 1'b1;
                aluop  = 3'b010;
            end
            OpAddi, OpAddiu, OpSw: begin
                alusrc = 1'b1;
                extop  = 1'b1;
            end
            OpLw: begin
                alusrc   = 1'b1;
                extop    = 1'b1;
                memtoreg = 1'b1;
            end
            OpBeq:   aluop = 3'b100;
            OpJ:     ;
            default: legal_op = 1'b0;
        endcase
    end

    assign mem_state = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
    assign done      = (HANDSHAKE == 0) || mem_rdy;
    // A ready arriving in the last allowed wait cycle wins over the timeout.
    assign timeout   = (HANDSHAKE != 0) && (TIMEOUT != 0) && mem_state && !mem_rdy &&
                       (cnt_q == CntW'(TIMEOUT - 1));

    always_comb begin
        state_d      = state_q;
        trap_cause_d = trap_cause_q;
        ir_we_c      = 1'b0;
        pc_we_c      = 1'b0;
        mem_rd_c     = 1'b0;
        mem_wr_c     = 1'b0;
        regwr_c      = 1'b0;
        pcsrc        = 2'b00;
        iord         = 1'b0;
        case (state_q)
            StFetch: begin
                if (timeout) begin
                    state_d      = StTrap;
                    trap_cause_d = 2'b10;
                end else begin
                    mem_rd_c = 1'b1;
                    if (done) begin
                        ir_we_c = 1'b1;
                        pc_we_c = 1'b1;
                        state_d = StDecode;
                    end
                end
            end
            StDecode: begin
                if (op == OpJ) begin
                    pc_we_c = 1'b1;
                    pcsrc   = 2'b10;
                    state_d = StFetch;
                end else if (legal_op) begin
                    state_d = StExec;
                end else begin
                    state_d      = StTrap;
                    trap_cause_d = 2'b01;
                end
            end
            StExec: begin
                case (op)
                    OpR, OpOri, OpAddi, OpAddiu: state_d = StWb;
                    OpLw:                        state_d = StMemRd;
                    OpSw:                        state_d = StMemWr;
                    OpBeq: begin
                        pc_we_c = zero;
                        pcsrc   = 2'b01;
                        state_d = StFetch;
                    end
                    default:                     state_d = StFetch;
                endcase
            end
            StMemRd: begin
                iord = 1'b1;
                if (timeout) begin
                    state_d      = StTrap;
                    trap_cause_d = 2'b10;
                end else begin
                    mem_rd_c = 1'b1;
                    if (done) state_d = StWb;
                end
            end
            StMemWr: begin
                iord = 1'b1;
                if (timeout) begin
                    state_d      = StTrap;
                    trap_cause_d = 2'b10;
                end else begin
                    mem_wr_c = 1'b1;
                    if (done) state_d = StFetch;
                end
            end
            StWb: begin
                regwr_c = 1'b1;
                state_d = StFetch;
            end
            StTrap:  state_d = StTrap;
            default: state_d = StFetch;
        endcase
    end

    // Wait counter restarts on every state change, so each memory state starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (mem_state && !mem_rdy && (cnt_q != {CntW{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StFetch;
            cnt_q        <= '0;
            trap_cause_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    // Strobes are held low for the whole time reset is asserted.
    assign ir_we      = ir_we_c & rst_n;
    assign pc_we      = pc_we_c & rst_n;
    assign mem_rd     = mem_rd_c & rst_n;
    assign mem_wr     = mem_wr_c & rst_n;
    assign regwr      = regwr_c & rst_n;
    assign trap       = (state_q == StTrap);
    assign trap_cause = trap_cause_q;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected control words are queued when
// stimulus is applied and compared against the DUT on the following falling edge.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n_a = 1'b0;
    logic       rst_n_b = 1'b0;
    logic [5:0] op = 6'b000000;
    logic       zero = 1'b0;
    logic       mem_rdy = 1'b0;
    logic       use_b = 1'b0;

    logic       ir_we_a, pc_we_a, mem_rd_a, mem_wr_a, regwr_a, iord_a, trap_a;
    logic       regdst_a, alusrc_a, memtoreg_a, extop_a, rtype_a;
    logic [1:0] pcsrc_a, cause_a;
    logic [2:0] aluop_a, state_a;
    logic       ir_we_b, pc_we_b, mem_rd_b, mem_wr_b, regwr_b, iord_b, trap_b;
    logic       regdst_b, alusrc_b, memtoreg_b, extop_b, rtype_b;
    logic [1:0] pcsrc_b, cause_b;
    logic [2:0] aluop_b, state_b;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [13:0] ctl;
        logic [7:0]  sel;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    multicycle_control #(.HANDSHAKE(1), .TIMEOUT(15)) u_dut_a (
        .clk(clk), .rst_n(rst_n_a), .op(op), .zero(zero), .mem_rdy(mem_rdy),
        .ir_we(ir_we_a), .pc_we(pc_we_a), .mem_rd(mem_rd_a), .mem_wr(mem_wr_a),
        .regwr(regwr_a), .pcsrc(pcsrc_a), .iord(iord_a), .regdst(regdst_a),
        .alusrc(alusrc_a), .memtoreg(memtoreg_a), .extop(extop_a), .rtype(rtype_a),
        .aluop(aluop_a), .trap(trap_a), .trap_cause(cause_a), .state(state_a)
    );

    multicycle_control #(.HANDSHAKE(1), .TIMEOUT(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .op(op), .zero(zero), .mem_rdy(mem_rdy),
        .ir_we(ir_we_b), .pc_we(pc_we_b), .mem_rd(mem_rd_b), .mem_wr(mem_wr_b),
        .regwr(regwr_b), .pcsrc(pcsrc_b), .iord(iord_b), .regdst(regdst_b),
        .alusrc(alusrc_b), .memtoreg(memtoreg_b), .extop(extop_b), .rtype(rtype_b),
        .aluop(aluop_b), .trap(trap_b), .trap_cause(cause_b), .state(state_b)
    );

    logic [13:0] ctl_a, ctl_b, ctl_obs;
    logic [7:0]  sel_a, sel_b, sel_obs;
    assign ctl_a = {state_a, ir_we_a, pc_we_a, mem_rd_a, mem_wr_a, regwr_a, pcsrc_a, iord_a,
                    trap_a, cause_a};
    assign ctl_b = {state_b, ir_we_b, pc_we_b, mem_rd_b, mem_wr_b, regwr_b, pcsrc_b, iord_b,
                    trap_b, cause_b};
    assign sel_a = {regdst_a, alusrc_a, memtoreg_a, extop_a, rtype_a, aluop_a};
    assign sel_b = {regdst_b, alusrc_b, memtoreg_b, extop_b, rtype_b, aluop_b};
    assign ctl_obs = use_b ? ctl_b : ctl_a;
    assign sel_obs = use_b ? sel_b : sel_a;

    // {regdst, alusrc, memtoreg, extop, rtype, aluop}
    function automatic logic [7:0] sel_model(input logic [5:0] o);
        case (o)
            6'b000000: return 8'b1_0_0_0_1_001;
            6'b001101: return 8'b0_1_0_0_0_010;
            6'b001001: return 8'b0_1_0_1_0_000;
            6'b001000: return 8'b0_1_0_1_0_000;
            6'b100011: return 8'b0_1_1_1_0_000;
            6'b101011: return 8'b0_1_0_1_0_000;
            6'b000100: return 8'b0_0_0_0_0_100;
            default:   return 8'b0;
        endcase
    endfunction

    // strb = {ir_we, pc_we, mem_rd, mem_wr, regwr}
    task automatic cyc(input string tag, input logic rdy, input logic [2:0] st,
                       input logic [4:0] strb, input logic [1:0] pcs, input logic io,
                       input logic [1:0] cause);
        exp_t e;
        mem_rdy = rdy;
        e.tag = tag;
        e.ctl = {st, strb, pcs, io, (st == 3'd6), cause};
        e.sel = sel_model(op);
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        assert (ctl_obs === e.ctl) else begin
            failures++;
            $error("FAIL %s ctl observed=%b expected=%b", e.tag, ctl_obs, e.ctl);
        end
        checks++;
        assert (sel_obs === e.sel) else begin
            failures++;
            $error("FAIL %s sel observed=%b expected=%b", e.tag, sel_obs, e.sel);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc("reset", 1'b1, 3'd0, 5'b00000, 2'b00, 1'b0, 2'b00);
        rst_n_a = 1'b1;

        op = 6'b000000;
        cyc("add_fetch", 1'b1, 3'd0, 5'b11100, 2'b00, 1'b0, 2'b00);
        cyc("add_dec",   1'b1, 3'd1, 5'b00000, 2'b00, 1'b0, 2'b00);
        cyc("add_exec",  1'b1, 3'd2, 5'b00000, 2'b00, 1'b0, 2'b00);
        cyc("add_wb",    1'b1, 3'd5, 5'b00001, 2'b00, 1'b0, 2'b00);

        op = 6'b100011;
        cyc("lw_fetch",  1'b1, 3'd0, 5'b11100, 2'b00, 1'b0, 2'b00);
        cyc("lw_dec",    1'b1, 3'd1, 5'b00000, 2'b00, 1'b0, 2'b00);
        cyc("lw_exec",   1'b1, 3'd2, 5'b00000, 2'b00, 1'b0, 2'b00);
        cyc("lw_wait0",  1'b0, 3'd3, 5'b00100, 2'b00, 1'b1, 2'b00);
        cyc("lw_wait1",  1'b0, 3'd3, 5'b00100, 2'b00, 1'b1, 2'b00);
        cyc("lw_rd",     1'b1, 3'd3, 5'b00100, 2'b00, 1'b1, 2'b00);
        cyc("lw_wb",     1'b1, 3'd5, 5'b00001, 2'b00, 1'b0, 2'b00);

        op = 6'b000100;
        zero = 1'b1;
        cyc("beq1_fetch", 1'b1, 3'd0, 5'b11100, 2'b00, 1'b0, 2'b00);
        cyc("beq1_dec",   1'b1, 3'd1, 5'b00000, 2'b00, 1'b0, 2'b00);
        cyc("beq1_exec",  1'b1, 3'd2, 5'b01000, 2'b01, 1'b0, 2'b00);
        zero = 1'b0;
        cyc("beq0_fetch", 1'b1, 3'd0, 5'b11100, 2'b00, 1'b0, 2'b00);
        cyc("beq0_dec",   1'b1, 3'd1, 5'b00000, 2'b00, 1'b0, 2'b00);
        cyc("beq0_exec",  1'b1, 3'd2, 5'b00000, 2'b01, 1'b0, 2'b00);

        op = 6'b000010;
        cyc("j_fetch", 1'b1, 3'd0, 5'b11100, 2'b00, 1'b0, 2'b00);
        cyc("j_dec",   1'b1, 3'd1, 5'b01000, 2'b10, 1'b0, 2'b00);

        op = 6'b101011;
        cyc("sw_fwait", 1'b0, 3'd0, 5'b00100, 2'b00, 1'b0, 2'b00);
        cyc("sw_fetch", 1'b1, 3'd0, 5'b11100, 2'b00, 1'b0, 2'b00);
        cyc("sw_dec",   1'b1, 3'd1, 5'b00000, 2'b00, 1'b0, 2'b00);
        cyc("sw_exec",  1'b1, 3'd2, 5'b00000, 2'b00, 1'b0, 2'b00);
        cyc("sw_wait",  1'b0, 3'd4, 5'b00010, 2'b00, 1'b1, 2'b00);
        cyc("sw_wr",    1'b1, 3'd4, 5'b00010, 2'b00, 1'b1, 2'b00);

        op = 6'b001001;
        cyc("addiu_fetch", 1'b1, 3'd0, 5'b11100, 2'b00, 1'b0, 2'b00);
        cyc("addiu_dec",   1'b1, 3'd1, 5'b00000, 2'b00, 1'b0, 2'b00);
        cyc("addiu_exec",  1'b1, 3'd2, 5'b00000, 2'b00, 1'b0, 2'b00);
        cyc("addiu_wb",    1'b1, 3'd5, 5'b00001, 2'b00, 1'b0, 2'b00);

        // Reset asserted while lw is stalled in MEMRD.
        op = 6'b100011;
        cyc("lwr_fetch", 1'b1, 3'd0, 5'b11100, 2'b00, 1'b0, 2'b00);
        cyc("lwr_dec",   1'b1, 3'd1, 5'b00000, 2'b00, 1'b0, 2'b00);
        cyc("lwr_exec",  1'b1, 3'd2, 5'b00000, 2'b00, 1'b0, 2'b00);
        cyc("lwr_w0",    1'b0, 3'd3, 5'b00100, 2'b00, 1'b1, 2'b00);
        cyc("lwr_w1",    1'b0, 3'd3, 5'b00100, 2'b00, 1'b1, 2'b00);
        cyc("lwr_w2",    1'b0, 3'd3, 5'b00100, 2'b00, 1'b1, 2'b00);
        rst_n_a = 1'b0;
        cyc("mid_reset", 1'b0, 3'd0, 5'b00000, 2'b00, 1'b0, 2'b00);
        rst_n_a = 1'b1;
        op = 6'b001101;
        cyc("ori_fwait", 1'b0, 3'd0, 5'b00100, 2'b00, 1'b0, 2'b00);
        cyc("ori_fetch", 1'b1, 3'd0, 5'b11100, 2'b00, 1'b0, 2'b00);
        cyc("ori_dec",   1'b1, 3'd1, 5'b00000, 2'b00, 1'b0, 2'b00);
        cyc("ori_exec",  1'b1, 3'd2, 5'b00000, 2'b00, 1'b0, 2'b00);
        cyc("ori_wb",    1'b1, 3'd5, 5'b00001, 2'b00, 1'b0, 2'b00);

        op = 6'b111111;
        cyc("ill_fetch", 1'b1, 3'd0, 5'b11100, 2'b00, 1'b0, 2'b00);
        cyc("ill_dec",   1'b1, 3'd1, 5'b00000, 2'b00, 1'b0, 2'b00);
        cyc("ill_trap0", 1'b1, 3'd6, 5'b00000, 2'b00, 1'b0, 2'b01);
        cyc("ill_trap1", 1'b1, 3'd6, 5'b00000, 2'b00, 1'b0, 2'b01);

        // Watchdog instance (TIMEOUT = 4).
        rst_n_a = 1'b0;
        rst_n_b = 1'b1;
        use_b = 1'b1;
        op = 6'b000010;
        cyc("wd_w0",     1'b0, 3'd0, 5'b00100, 2'b00, 1'b0, 2'b00);
        cyc("wd_w1",     1'b0, 3'd0, 5'b00100, 2'b00, 1'b0, 2'b00);
        cyc("wd_w2",     1'b0, 3'd0, 5'b00100, 2'b00, 1'b0, 2'b00);
        cyc("wd_late",   1'b1, 3'd0, 5'b11100, 2'b00, 1'b0, 2'b00);
        cyc("wd_j",      1'b1, 3'd1, 5'b01000, 2'b10, 1'b0, 2'b00);
        cyc("wd_t0",     1'b0, 3'd0, 5'b00100, 2'b00, 1'b0, 2'b00);
        cyc("wd_t1",     1'b0, 3'd0, 5'b00100, 2'b00, 1'b0, 2'b00);
        cyc("wd_t2",     1'b0, 3'd0, 5'b00100, 2'b00, 1'b0, 2'b00);
        cyc("wd_expire", 1'b0, 3'd0, 5'b00000, 2'b00, 1'b0, 2'b00);
        cyc("wd_trap0",  1'b1, 3'd6, 5'b00000, 2'b00, 1'b0, 2'b10);
        cyc("wd_trap1",  1'b1, 3'd6, 5'b00000, 2'b00, 1'b0, 2'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle successor to the single-cycle MIPS decoder. It sequences each instruction through fetch, decode, execute, memory and write-back states, and waits on a memory ready handshake with an optional timeout. It traps on illegal opcodes. It sits between the instruction register, the shared instruction/data memory port and the datapath. It supplies the same static datapath selects (regdst, alusrc, extop, aluop, rtype, memtoreg) as before, plus per-state write strobes.

## Interface
- HANDSHAKE, 1, 1: memory states wait for mem_rdy; 0: memory states always last exactly 1 cycle and mem_rdy is ignored.
- TIMEOUT, 15, maximum wait cycles in a memory state before trapping; 0 disables the watchdog; counter width is clog2(TIMEOUT+1).
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- op  input  6  opcode from the instruction register; stable from DECODE onward.
- zero  input  1  ALU zero flag, sampled in EXEC for beq.
- mem_rdy  input  1  memory access completes this cycle.
- ir_we, pc_we, mem_rd, mem_wr, regwr  output  1 each  state strobes.
- pcsrc  output  2  PC source: 00 = PC+4, 01 = branch target, 10 = jump target.
- iord  output  1  memory address select: 0 = PC, 1 = ALU result.
- regdst, alusrc, memtoreg, extop, rtype  output  1 each  static selects.
- aluop  output  3  ALU operation class.
- trap  output  1  sticky error flag.
- trap_cause  output  2  01 = illegal opcode, 10 = memory timeout, 00 = none.
- state  output  3  current state, for debug.

## Operation
- Supported opcodes: r = 000000, ori = 001101, addiu = 001001, addi = 001000, lw = 100011, sw = 101011, beq = 000100, j = 000010.
- Static selects are decoded combinationally from op and are valid in every state:
  - r: regdst = 1, rtype = 1, aluop = 001.
  - ori: alusrc = 1, aluop = 010, extop = 0.
  - addi and addiu: alusrc = 1, aluop = 000, extop = 1.
  - lw: same as addi, plus memtoreg = 1.
  - sw: alusrc = 1, extop = 1, aluop = 000.
  - beq: aluop = 100.
  - j, and any unlisted opcode: all static selects 0.
- State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEMRD = 3, MEMWR = 4, WB = 5, TRAP = 6.
- FETCH: mem_rd = 1, iord = 0. When the access is done (mem_rdy, or HANDSHAKE = 0), assert ir_we = 1 and pc_we = 1 with pcsrc = 00, then go to DECODE.
- DECODE:
  - j: pc_we = 1, pcsrc = 10, go to FETCH.
  - Unlisted op: go to TRAP with cause 01.
  - Otherwise go to EXEC.
- EXEC:
  - R-type, ori, addi, addiu: go to WB.
  - lw: go to MEMRD.
  - sw: go to MEMWR.
  - beq: pc_we = zero, pcsrc = 01, go to FETCH.
- MEMRD: mem_rd = 1, iord = 1. When done, go to WB.
- MEMWR: mem_wr = 1, iord = 1. When done, go to FETCH.
- WB: regwr = 1 for one cycle, then go to FETCH.
- Watchdog:
  - The wait counter clears on entry to any memory state and increments each cycle without mem_rdy.
  - If the counter reaches TIMEOUT with mem_rdy still low, go to TRAP with cause 10. No strobe fires on that cycle.
- TRAP: trap = 1, all strobes 0. TRAP is left only by reset.
- Strobes not listed for a state are 0. pcsrc is 00 and iord is 0 wherever they are unused.

## Timing
- Reset (rst_n low, asynchronous):
  - Takes effect immediately, including mid-instruction or mid-wait.
  - Resulting values: state = FETCH, wait counter = 0, trap = 0, trap_cause = 00.
  - All strobes are forced to 0 while rst_n is low, including mem_rd.
  - The first fetch request appears in the cycle after rst_n deasserts.
- Strobes are combinational from the state register (plus mem_rdy and zero), so they are valid in the same cycle.
- Latency with mem_rdy tied high: R-type/ori/addi/addiu = 4 cycles, lw = 5, sw = 4, beq = 3, j = 2.
- Each cycle mem_rdy is low in FETCH, MEMRD or MEMWR adds exactly one cycle. Strobes gated by completion (ir_we, pc_we) fire only in the completing cycle.
- mem_rdy arriving on the same cycle the counter reaches TIMEOUT counts as completion, not a timeout.
- With TIMEOUT = 0, the wait is unbounded.

## Test plan
- Reset mid-MEMRD (lw, mem_rdy low for 3 cycles, then rst_n pulsed low) -> state = 0 and all strobes 0 immediately. After release, mem_rd = 1 and iord = 0 next cycle.
- add (op = 000000), mem_rdy = 1 -> states 0,1,2,5,0. ir_we and pc_we in cycle 0, regwr in cycle 3, regdst = 1, aluop = 001.
- lw with mem_rdy low for 2 cycles in MEMRD -> 7-cycle instruction. memtoreg = 1 and extop = 1 throughout; regwr only in WB.
- beq with zero = 1, then beq with zero = 0 -> first gives pc_we = 1 with pcsrc = 01 in EXEC; second gives pc_we = 0 in EXEC. Both return to FETCH after 3 cycles.
- j -> pc_we = 1 with pcsrc = 10 in DECODE; 2-cycle instruction.
- op = 111111 -> TRAP with trap_cause = 01. Separately, with TIMEOUT = 4 and mem_rdy held low in FETCH -> TRAP with trap_cause = 10 after 4 wait cycles, and mem_rdy afterwards is ignored.
